// File: rtl/wb_stream_controller.sv
// Wishbone classic controller: turns a valid/ready command stream into single read/write
// cycles, with bounded rty re-issue and a wait-state timeout, and returns one response per command.
module wb_stream_controller #(
    parameter int DAT_WIDTH      = 8,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_we_i,
    input  logic [DAT_WIDTH-1:0] cmd_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DAT_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]           rsp_status_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    input  logic [DAT_WIDTH-1:0] dat_i
);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_RFAIL = 2'b10;
    localparam logic [1:0] ST_TMO   = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF, RSP} state_e;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]           status_q, status_d;
    logic                 cyc_q, rsp_valid_q, ready_q;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        dat_d     = dat_q;
        retry_d   = retry_q;
        wait_d    = wait_q;
        rsp_dat_d = rsp_dat_q;
        status_d  = status_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    we_d    = cmd_we_i;
                    dat_d   = cmd_dat_i;
                    retry_d = '0;
                    wait_d  = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // err outranks rty, which outranks ack
                if (err_i) begin
                    status_d  = ST_ERR;
                    rsp_dat_d = '0;
                    state_d   = RSP;
                end else if (rty_i) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = BACKOFF;
                    end else begin
                        status_d  = ST_RFAIL;
                        rsp_dat_d = '0;
                        state_d   = RSP;
                    end
                end else if (ack_i) begin
                    status_d  = ST_OK;
                    rsp_dat_d = we_q ? '0 : dat_i;
                    state_d   = RSP;
                end else if (TIMEOUT_CYCLES != 0 && wait_q == WAIT_LAST) begin
                    status_d  = ST_TMO;
                    rsp_dat_d = '0;
                    state_d   = RSP;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            BACKOFF: begin
                wait_d  = '0;
                state_d = REQ;
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from next-state so every port is a plain register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            dat_q       <= '0;
            retry_q     <= '0;
            wait_q      <= '0;
            rsp_dat_q   <= '0;
            status_q    <= ST_OK;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            retry_q     <= retry_d;
            wait_q      <= wait_d;
            rsp_dat_q   <= rsp_dat_d;
            status_q    <= status_d;
            cyc_q       <= (state_d == REQ);
            rsp_valid_q <= (state_d == RSP);
            ready_q     <= (state_d == IDLE);
        end
    end

    assign cmd_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = status_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = we_q;
    assign dat_o        = dat_q;

endmodule

// File: tb/tb_wb_stream_controller.sv
// Randomized and directed bench for wb_stream_controller; a scripted Wishbone device
// drives terminations and a transaction-level model predicts each response.
module tb_wb_stream_controller;
    localparam int DW = 8;
    localparam int MR = 3;
    localparam int TO = 8;

    localparam int T_ACK = 0, T_ERR = 1, T_RTY = 2, T_NONE = 3, T_ERRACK = 4, T_RTYACK = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [DW-1:0] cmd_dat = '0, rd_dat = '0;
    logic          ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic          cmd_ready_o, rsp_valid_o, cyc_o, stb_o, we_o;
    logic [DW-1:0] rsp_dat_o, dat_o;
    logic [1:0]    rsp_status_o;

    int total = 0;
    int bad = 0;

    int            ty_a[8];
    int            dl_a[8];
    logic [DW-1:0] rd_a[8];
    int            n_a;

    wb_stream_controller #(.DAT_WIDTH(DW), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
        .rsp_status_o(rsp_status_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .dat_o(dat_o),
        .ack_i(ack), .err_i(err), .rty_i(rty), .dat_i(rd_dat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Protocol watch: stb mirrors cyc, request held stable while cyc stays high.
    logic          pcyc = 1'b0, pwe = 1'b0;
    logic [DW-1:0] pdat = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stb_eq_cyc", 32'(stb_o), 32'(cyc_o));
            if (cyc_o) chk("ready_in_cyc", 32'(cmd_ready_o), 0);
            if (pcyc && cyc_o) begin
                chk("we_stable", 32'(we_o), 32'(pwe));
                chk("dat_stable", 32'(dat_o), 32'(pdat));
            end
        end
        pcyc <= cyc_o && rst_n;
        pwe  <= we_o;
        pdat <= dat_o;
    end

    // Transaction-level outcome: walk the device script applying priority and retry budget.
    function automatic void model(input logic we, output int used, output logic [1:0] st,
                                  output logic [DW-1:0] d);
        int r;
        r = 0; used = 0; st = 2'b00; d = '0;
        for (int k = 0; k < n_a; k++) begin
            used = k + 1;
            case (ty_a[k])
                T_NONE:           begin st = 2'b11; d = '0; return; end
                T_ERR, T_ERRACK:  begin st = 2'b01; d = '0; return; end
                T_RTY, T_RTYACK:  if (r < MR) r++; else begin st = 2'b10; d = '0; return; end
                default:          begin st = 2'b00; d = we ? '0 : rd_a[k]; return; end
            endcase
        end
    endfunction

    task automatic set_att(input int k, input int t, input int d, input logic [DW-1:0] r);
        ty_a[k] = t; dl_a[k] = d; rd_a[k] = r;
    endtask

    task automatic junk_terms();
        ack = 1'($urandom); err = 1'($urandom); rty = 1'($urandom); rd_dat = DW'($urandom);
    endtask

    task automatic clear_terms();
        ack = 1'b0; err = 1'b0; rty = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [DW-1:0] wd, input int rwait);
        int            used, cnt;
        logic [1:0]    est;
        logic [DW-1:0] ed;
        model(we, used, est, ed);
        cmd_valid = 1'b1; cmd_we = we; cmd_dat = wd;
        cnt = 0;
        while (!cmd_ready_o && cnt < 50) begin @(negedge clk); cnt++; end
        chk("accept_ready", 32'(cmd_ready_o), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_dat = DW'($urandom); cmd_we = 1'($urandom);
        chk("cyc_after_accept", 32'(cyc_o), 1);
        chk("we_o", 32'(we_o), 32'(we));
        chk("dat_o", 32'(dat_o), 32'(wd));
        for (int k = 0; k < used; k++) begin
            if (ty_a[k] == T_NONE) begin
                cnt = 1;
                while (cyc_o && cnt < 40) begin @(negedge clk); if (cyc_o) cnt++; end
                chk("timeout_len", 32'(cnt), TO);
            end else begin
                repeat (dl_a[k]) begin
                    @(negedge clk);
                    chk("cyc_hold", 32'(cyc_o), 1);
                    chk("we_hold", 32'(we_o), 32'(we));
                    chk("dat_hold", 32'(dat_o), 32'(wd));
                end
                ack = (ty_a[k] == T_ACK) || (ty_a[k] == T_ERRACK) || (ty_a[k] == T_RTYACK);
                err = (ty_a[k] == T_ERR) || (ty_a[k] == T_ERRACK);
                rty = (ty_a[k] == T_RTY) || (ty_a[k] == T_RTYACK);
                rd_dat = rd_a[k];
                @(negedge clk);
                clear_terms();
                chk("cyc_drop", 32'(cyc_o), 0);
            end
            if (k < used - 1) begin
                chk("no_rsp_in_backoff", 32'(rsp_valid_o), 0);
                junk_terms();
                @(negedge clk);
                clear_terms();
                chk("backoff_one_cycle", 32'(cyc_o), 1);
            end
        end
        chk("rsp_valid", 32'(rsp_valid_o), 1);
        chk("rsp_status", 32'(rsp_status_o), 32'(est));
        chk("rsp_dat", 32'(rsp_dat_o), 32'(ed));
        cmd_valid = 1'b1; cmd_dat = DW'($urandom);
        repeat (rwait) begin
            junk_terms();
            @(negedge clk);
            chk("rsp_hold_valid", 32'(rsp_valid_o), 1);
            chk("rsp_hold_status", 32'(rsp_status_o), 32'(est));
            chk("rsp_hold_dat", 32'(rsp_dat_o), 32'(ed));
            chk("ready_low_in_rsp", 32'(cmd_ready_o), 0);
            chk("cyc_low_in_rsp", 32'(cyc_o), 0);
        end
        clear_terms();
        rsp_ready = 1'b1; cmd_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_drop", 32'(rsp_valid_o), 0);
        chk("ready_after_rsp", 32'(cmd_ready_o), 1);
    endtask

    initial begin
        int cnt, n;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(cyc_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_ready", 32'(cmd_ready_o), 0);
        chk("rst_status", 32'(rsp_status_o), 0);
        chk("rst_rsp_dat", 32'(rsp_dat_o), 0);
        chk("rst_we", 32'(we_o), 0);
        chk("rst_dat", 32'(dat_o), 0);
        rst_n = 1'b1;
        cnt = 0;
        while (!cmd_ready_o && cnt < 6) begin @(negedge clk); cnt++; end
        chk("ready_after_reset", 32'(cmd_ready_o), 1);

        n_a = 1; set_att(0, T_ACK, 2, 8'h77);
        do_txn(1'b1, 8'hA5, 0);
        n_a = 1; set_att(0, T_ACK, 0, 8'h3C);
        do_txn(1'b0, 8'h00, 1);
        n_a = 3; set_att(0, T_RTY, 0, 8'h00); set_att(1, T_RTY, 1, 8'h00); set_att(2, T_ACK, 0, 8'h11);
        do_txn(1'b0, 8'h00, 0);
        n_a = 4; for (int k = 0; k < 4; k++) set_att(k, T_RTY, k % 2, 8'h22);
        do_txn(1'b0, 8'h00, 0);
        n_a = 1; set_att(0, T_NONE, 0, 8'h00);
        do_txn(1'b0, 8'h00, 0);
        n_a = 1; set_att(0, T_ERRACK, 1, 8'h5A);
        do_txn(1'b0, 8'h00, 5);
        n_a = 2; set_att(0, T_RTYACK, 0, 8'h99); set_att(1, T_ACK, 3, 8'hC3);
        do_txn(1'b0, 8'h00, 2);

        for (int i = 0; i < 40; i++) begin
            n = int'($urandom_range(1, 6));
            n_a = n;
            for (int k = 0; k < n - 1; k++)
                set_att(k, int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), DW'($urandom));
            case ($urandom_range(0, 3))
                0: set_att(n - 1, T_ACK, int'($urandom_range(0, 4)), DW'($urandom));
                1: set_att(n - 1, T_ERR, int'($urandom_range(0, 4)), DW'($urandom));
                2: set_att(n - 1, T_ERRACK, int'($urandom_range(0, 4)), DW'($urandom));
                default: set_att(n - 1, T_NONE, 0, DW'($urandom));
            endcase
            do_txn(1'($urandom), DW'($urandom), int'($urandom_range(0, 5)));
        end

        // reset while a cycle is open
        cmd_valid = 1'b1; cmd_we = 1'b0;
        cnt = 0;
        while (!cmd_ready_o && cnt < 50) begin @(negedge clk); cnt++; end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("cyc_before_reset", 32'(cyc_o), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", 32'(cyc_o), 0);
        chk("rst_mid_stb", 32'(stb_o), 0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_mid_ready", 32'(cmd_ready_o), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!cmd_ready_o && cnt < 6) begin @(negedge clk); cnt++; end
        chk("idle_after_reset", 32'(cmd_ready_o), 1);
        repeat (3) @(negedge clk);
        chk("no_cyc_after_reset", 32'(cyc_o), 0);
        chk("no_rsp_after_reset", 32'(rsp_valid_o), 0);

        n_a = 1; set_att(0, T_ACK, 1, 8'h4E);
        do_txn(1'b0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
